// File: rtl/phy_rx_pkg.sv
// Shared constants for the multilane PHY receive path: byte width, default COM symbol
// and the per-lane alignment state encoding.
package phy_rx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  localparam byte_t COM_SYM_DEF = 8'hBC;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/phy_rx_multilane_if.sv
// Lane pins in, unstriped word bus and link status out.
interface phy_rx_multilane_if #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned WORD_BYTES = 4
);
  logic [LANES-1:0]        data_in;
  logic [8*WORD_BYTES-1:0] data_out;
  logic                    valid_out;
  logic [LANES-1:0]        lane_locked;
  logic                    all_locked;
  logic                    overflow;

  modport master (
    input  data_in,
    output data_out, valid_out, lane_locked, all_locked, overflow
  );

  modport slave (
    output data_in,
    input  data_out, valid_out, lane_locked, all_locked, overflow
  );
endinterface

// File: rtl/phy_rx_lane.sv
// One receive lane: bit deserialiser, COM alignment FSM, byte->word packer and holding register.
// PHY_RX_ERR_CNT_EN adds a pulse output flagging ALIGN->SEARCH fallbacks.
module phy_rx_lane
  import phy_rx_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 4,
  parameter byte_t       COM_SYM    = COM_SYM_DEF,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                           clk_32f,
  input  logic                           reset,
  input  logic                           data_in,
  input  logic                           load_en,
  output logic [BYTE_W*WORD_BYTES-1:0]   word,
  output logic                           word_done,
  output logic                           locked
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic                           fallback
`endif
);

  localparam int unsigned SlotW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(WORD_BYTES - 1);

  logic [1:0]       state_q, state_d;
  // Seven bits of history; with the incoming bit they form the current 8-bit window.
  logic [6:0]       sr_q, sr_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       com_cnt_q, com_cnt_d;
  byte_t            byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [WORD_BYTES-1:0][BYTE_W-1:0] buf_q, buf_d;
  logic [BYTE_W*WORD_BYTES-1:0]      hold_q, hold_d;

  byte_t cur;
  logic  boundary;

  assign cur      = {sr_q, data_in};
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d    = state_q;
    sr_d       = cur[6:0];
    bit_cnt_d  = bit_cnt_q + 3'd1;
    com_cnt_d  = com_cnt_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
`ifdef PHY_RX_ERR_CNT_EN
    fallback   = 1'b0;
`endif
    case (state_q)
      ST_SEARCH: begin
        if (cur == COM_SYM) begin
          bit_cnt_d = '0;
          com_cnt_d = 4'd1;
          state_d   = (LOCK_COUNT <= 1) ? ST_LOCKED : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (boundary) begin
          if (cur == COM_SYM) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (32'(com_cnt_q) + 32'd1 >= LOCK_COUNT) state_d = ST_LOCKED;
          end else begin
            state_d   = ST_SEARCH;
            com_cnt_d = '0;
`ifdef PHY_RX_ERR_CNT_EN
            fallback  = 1'b1;
`endif
          end
        end
      end
      ST_LOCKED: begin
        // COM bytes after lock are idles and never reach the packer.
        if (boundary && (cur != COM_SYM)) begin
          byte_vld_d = 1'b1;
          byte_d     = cur;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_comb begin
    buf_d     = buf_q;
    slot_d    = slot_q;
    hold_d    = hold_q;
    word_done = 1'b0;
    if (byte_vld_q) begin
      buf_d[slot_q] = byte_q;
      if (slot_q == LastSlot) begin
        word_done = 1'b1;
        slot_d    = '0;
        // A refused word is dropped so the unconsumed one stays intact.
        if (load_en) hold_d = buf_d;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_SEARCH;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      com_cnt_q  <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      slot_q     <= '0;
      buf_q      <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      slot_q     <= slot_d;
      buf_q      <= buf_d;
      hold_q     <= hold_d;
    end
  end

  assign word   = hold_q;
  assign locked = (state_q == ST_LOCKED);

endmodule

// File: rtl/phy_rx_multilane.sv
// Multilane PHY receive top: per-lane receivers plus strict round-robin unstriper.
// Defining PHY_RX_ERR_CNT_EN adds the saturating err_cnt port (dropped words + fallbacks).
module phy_rx_multilane
  import phy_rx_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned WORD_BYTES = 4,
  parameter byte_t       COM_SYM    = COM_SYM_DEF,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                clk_32f,
  input  logic                reset,
  phy_rx_multilane_if.master  rx
`ifdef PHY_RX_ERR_CNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam int unsigned PtrW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned WordW = BYTE_W * WORD_BYTES;

  logic [LANES-1:0][WordW-1:0] lane_word;
  logic [LANES-1:0] lane_done, lane_locked, load_en, consume, drop;
  logic [LANES-1:0] pending_q, pending_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [WordW-1:0] data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             overflow_q, overflow_d;
  logic             head_pending;
`ifdef PHY_RX_ERR_CNT_EN
  logic [LANES-1:0] lane_fallback;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [4:0]       err_inc;
  logic [16:0]      err_sum;
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    phy_rx_lane #(
      .WORD_BYTES (WORD_BYTES),
      .COM_SYM    (COM_SYM),
      .LOCK_COUNT (LOCK_COUNT)
    ) u_lane (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .data_in   (rx.data_in[gi]),
      .load_en   (load_en[gi]),
      .word      (lane_word[gi]),
      .word_done (lane_done[gi]),
      .locked    (lane_locked[gi])
`ifdef PHY_RX_ERR_CNT_EN
      ,
      .fallback  (lane_fallback[gi])
`endif
    );
  end

  // The pointer only advances on a consumed word, so a silent lane stalls every lane.
  always_comb begin
    head_pending = pending_q[ptr_q];
    consume      = '0;
    if (head_pending) consume[ptr_q] = 1'b1;
    valid_d    = head_pending;
    data_out_d = head_pending ? lane_word[ptr_q] : data_out_q;
    ptr_d      = ptr_q;
    if (head_pending) ptr_d = (ptr_q == PtrW'(LANES - 1)) ? '0 : ptr_q + 1'b1;
    load_en    = ~pending_q | consume;
    drop       = lane_done & ~load_en;
    pending_d  = (pending_q & ~consume) | (lane_done & load_en);
    overflow_d = overflow_q | (|drop);
  end

`ifdef PHY_RX_ERR_CNT_EN
  always_comb begin
    err_inc = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      err_inc = err_inc + 5'(drop[i]) + 5'(lane_fallback[i]);
    end
    err_sum   = 17'(err_cnt_q) + 17'(err_inc);
    err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end
`endif

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      ptr_q      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef PHY_RX_ERR_CNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
`ifdef PHY_RX_ERR_CNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign rx.data_out    = data_out_q;
  assign rx.valid_out   = valid_q;
  assign rx.lane_locked = lane_locked;
  assign rx.all_locked  = &lane_locked;
  assign rx.overflow    = overflow_q;
`ifdef PHY_RX_ERR_CNT_EN
  assign err_cnt        = err_cnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Directed bench for phy_rx_multilane (LANES=2, WORD_BYTES=4) with a byte-level reference model.
module tb_phy_rx_multilane;

  localparam int unsigned LANES = 2;
  localparam int unsigned WB    = 4;
  localparam int unsigned LOCK  = 4;
  localparam logic [7:0]  COM   = 8'hBC;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_32f = ~clk_32f;

  phy_rx_multilane_if #(.LANES(LANES), .WORD_BYTES(WB)) rx_if ();
`ifdef PHY_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
  int          err_model = 0;
`endif

  phy_rx_multilane #(
    .LANES      (LANES),
    .WORD_BYTES (WB),
    .COM_SYM    (COM),
    .LOCK_COUNT (LOCK)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .rx      (rx_if)
`ifdef PHY_RX_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  int   n_vec = 0;
  int   n_err = 0;
  wq_t  exp_q;
  wq_t  scn_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Every output word must be the next one the model predicts.
  task automatic compare_loop();
    logic [31:0] e;
    forever begin
      @(negedge clk_32f);
      if (reset && (rx_if.valid_out !== 1'b0)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_word: got %0h, expected no valid_out", rx_if.data_out);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {32'd0, rx_if.data_out}, {32'd0, e});
        end
      end
    end
  endtask

  // Byte-aligned view of one lane: COM run to lock, then pack non-COM bytes.
  function automatic void lane_model(input bq_t b, output wq_t w, output bit lk, output int fb);
    int          run;
    int          nb;
    logic [31:0] acc;
    run = 0; nb = 0; acc = '0; w = {}; lk = 1'b0; fb = 0;
    foreach (b[i]) begin
      if (!lk) begin
        if (b[i] == COM) begin
          run++;
          if (run >= int'(LOCK)) lk = 1'b1;
        end else begin
          if (run > 0) fb++;
          run = 0;
        end
      end else if (b[i] != COM) begin
        acc = acc | (32'(b[i]) << (8 * nb));
        nb++;
        if (nb == int'(WB)) begin
          w.push_back(acc);
          acc = '0;
          nb  = 0;
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b0, input logic [7:0] b1);
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk_32f);
      rx_if.data_in = {b1[k], b0[k]};
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},    64'(rx_if.valid_out),   64'd0);
    check({tag, "_data"},     64'(rx_if.data_out),    64'd0);
    check({tag, "_locked"},   64'(rx_if.lane_locked), 64'd0);
    check({tag, "_all"},      64'(rx_if.all_locked),  64'd0);
    check({tag, "_overflow"}, 64'(rx_if.overflow),    64'd0);
`ifdef PHY_RX_ERR_CNT_EN
    check({tag, "_err_cnt"},  64'(err_cnt),           64'd0);
`endif
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk_32f);
    reset = 1'b0;
    rx_if.data_in = '0;
    #1;
    check_reset_outputs(tag);
    exp_q = {};
`ifdef PHY_RX_ERR_CNT_EN
    err_model = 0;
`endif
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic run_scn(input string tag, input bq_t b0, input bq_t b1,
                         input logic [7:0] pad0, input logic [7:0] pad1,
                         input logic [1:0] lock_req, input logic ovf_req,
                         input int drops, input bit lat);
    wq_t w0, w1;
    bit  l0, l1;
    int  f0, f1, i0, i1, p, n;
    lane_model(b0, w0, l0, f0);
    lane_model(b1, w1, l1, f1);
    check({tag, "_model_lock"}, 64'({l1, l0}), 64'(lock_req));
    scn_exp = {};
    i0 = 0; i1 = 0; p = 0;
    for (int guard = 0; guard < 64; guard++) begin
      if (p == 0) begin
        if (i0 >= w0.size()) break;
        scn_exp.push_back(w0[i0]);
        i0++;
      end else begin
        if (i1 >= w1.size()) break;
        scn_exp.push_back(w1[i1]);
        i1++;
      end
      p = 1 - p;
    end
    exp_q = scn_exp;
    n = (b0.size() > b1.size()) ? b0.size() : b1.size();
    for (int i = 0; i < n; i++) begin
      send_byte((i < b0.size()) ? b0[i] : pad0, (i < b1.size()) ? b1[i] : pad1);
    end
    fork
      repeat (8) send_byte(pad0, pad1);
      begin
        if (lat) begin
          for (int k = 1; k <= 3; k++) begin
            @(negedge clk_32f);
            check({tag, "_latency"}, 64'(rx_if.valid_out), 64'(k == 3));
          end
        end
      end
    join
    check({tag, "_drained"},  64'(exp_q.size()),      64'd0);
    check({tag, "_locked"},   64'(rx_if.lane_locked), 64'(lock_req));
    check({tag, "_all"},      64'(rx_if.all_locked),  64'(&lock_req));
    check({tag, "_overflow"}, 64'(rx_if.overflow),    64'(ovf_req));
`ifdef PHY_RX_ERR_CNT_EN
    err_model += f0 + f1 + drops;
    check({tag, "_err_cnt"},  64'(err_cnt),           64'(err_model));
`endif
  endtask

  initial begin
    bq_t a, b;
    rx_if.data_in = '0;
    fork
      compare_loop();
    join_none
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    repeat (3) @(negedge clk_32f);
    reset = 1'b1;

    // Lock both lanes, leave half-built words, then reset mid-byte.
    a = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h01, 8'h02};
    b = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h05, 8'h06};
    run_scn("s1", a, b, COM, COM, 2'b11, 1'b0, 0, 1'b0);
    @(negedge clk_32f);
    rx_if.data_in = 2'b11;
    repeat (3) @(negedge clk_32f);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    exp_q = {};
`ifdef PHY_RX_ERR_CNT_EN
    err_model = 0;
`endif
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
    rx_if.data_in = '0;
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, 8'h00);
    check("post_reset_unlocked", 64'(rx_if.lane_locked), 64'd0);

    // Partial bytes from before the reset must not leak into these words.
    a = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h01, 8'h02, 8'h03, 8'h04};
    b = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h05, 8'h06, 8'h07, 8'h08};
    run_scn("s2", a, b, COM, COM, 2'b11, 1'b0, 0, 1'b1);
    check("s2_pin_n",  64'(scn_exp.size()), 64'd2);
    check("s2_pin_w0", 64'(scn_exp[0]),     64'h04030201);
    check("s2_pin_w1", 64'(scn_exp[1]),     64'h08070605);

    apply_reset("rst3");
    a = {8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    b = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_scn("s3", a, b, COM, COM, 2'b11, 1'b0, 0, 1'b0);
    check("s3_pin_w0", 64'(scn_exp[0]), 64'hA4A3A2A1);
    check("s3_pin_w1", 64'(scn_exp[1]), 64'hB4B3B2B1);

    apply_reset("rst4");
    a = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h11, 8'hBC, 8'h22, 8'h33, 8'h44};
    b = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h55, 8'h66, 8'hBC, 8'h77, 8'h88};
    run_scn("s4", a, b, COM, COM, 2'b11, 1'b0, 0, 1'b0);
    check("s4_pin_w0", 64'(scn_exp[0]), 64'h44332211);
    check("s4_pin_w1", 64'(scn_exp[1]), 64'h88776655);

    // Lane1 never locks: lane0 word 0 goes out, word 1 waits, word 2 is lost.
    apply_reset("rst5");
    a = {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8,
         8'hC9, 8'hCA, 8'hCB, 8'hCC};
    b = {};
    run_scn("s5", a, b, COM, 8'h00, 2'b01, 1'b1, 1, 1'b0);
    check("s5_pin_n",  64'(scn_exp.size()), 64'd1);
    check("s5_pin_w0", 64'(scn_exp[0]),     64'hC4C3C2C1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
